// File: rtl/multi_sram_pkg.sv
// multi_sram_pkg: shared bank geometry so sram_controller and multi_sram agree on bus layout.
package multi_sram_pkg;
    localparam int NUM_SRAMS      = 8;
    localparam int MAX_ADDR_WIDTH = 12;
    localparam int MAX_DATA_WIDTH = 32;
    localparam int SRAM_WIDTH_O   = 32;
endpackage

// File: rtl/sram_bank.sv
// sram_bank: single-port synchronous RAM with registered, width-adjusted read output.
// Define MULTI_SRAM_WRITE_FIRST_EN for write-first output on write cycles (default read-first).
module sram_bank
    import multi_sram_pkg::*;
#(
    parameter int AW = MAX_ADDR_WIDTH,
    parameter int DW = MAX_DATA_WIDTH,
    parameter int OW = SRAM_WIDTH_O
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [DW-1:0]        din,
    output logic signed [OW-1:0] dout
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] word;
    logic [OW-1:0] adj;
`ifdef MULTI_SRAM_WRITE_FIRST_EN
    assign word = we ? din : mem[addr];
`else
    assign word = mem[addr];
`endif
    generate
        if (OW > DW) begin : g_sext
            assign adj = {{(OW-DW){word[DW-1]}}, word};
        end else begin : g_trunc
            assign adj = word[OW-1:0];
        end
    endgenerate
    // Reset clears only the output register; stored words survive and the access is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (en) begin
            if (we) mem[addr] <= din;
            dout <= adj;
        end
    end
endmodule

// File: rtl/multi_sram.sv
// multi_sram: NUM_SRAMS independent single-port SRAM banks behind flattened per-bank buses.
// Read-during-write behaviour selected by MULTI_SRAM_WRITE_FIRST_EN (see sram_bank).
module multi_sram
    import multi_sram_pkg::*;
#(
    parameter int N  = NUM_SRAMS,
    parameter int AW = MAX_ADDR_WIDTH,
    parameter int DW = MAX_DATA_WIDTH,
    parameter int OW = SRAM_WIDTH_O
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           en,
    input  logic [N-1:0]           we,
    input  logic [N*AW-1:0]        addr,
    input  logic [N*DW-1:0]        data_in,
    output logic signed [N*OW-1:0] data_out
);
    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bank
            sram_bank #(.AW(AW), .DW(DW), .OW(OW)) u_bank (
                .clk  (clk),
                .rst  (rst),
                .en   (en[i]),
                .we   (we[i]),
                .addr (addr[i*AW +: AW]),
                .din  (data_in[i*DW +: DW]),
                .dout (data_out[i*OW +: OW])
            );
        end
    endgenerate
endmodule

// File: tb/tb_multi_sram.sv
// tb_multi_sram: directed self-checking bench for multi_sram.
module tb_multi_sram;
    import multi_sram_pkg::*;
    logic         clk = 0;
    logic         rst;
    logic [7:0]   en, we;
    logic [95:0]  addr;
    logic [255:0] data_in;
    logic signed [255:0] data_out;
    int n_chk = 0, n_pass = 0;

    multi_sram dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] slice(input int b);
        return data_out[b*32 +: 32];
    endfunction

    task automatic acc(input int b, input bit w, input logic [11:0] a, input logic [31:0] d);
        en[b] = 1'b1;
        we[b] = w;
        addr[b*12 +: 12] = a;
        data_in[b*32 +: 32] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        en = '0;
        we = '0;
    endtask

    initial begin
        rst = 1; en = '0; we = '0; addr = '0; data_in = '0;
        step(); step();
        check("reset_init", data_out, '0);
        rst = 0;
        acc(0, 1, 12'd5, 32'h11); step();
        acc(0, 0, 12'd5, 32'h0); step();
        check("pre_rst_read", 256'(slice(0)), 256'h11);
        // reset pulse with a read in flight: access dropped, outputs zeroed
        rst = 1; acc(0, 0, 12'd5, 32'h0); step(); rst = 0;
        check("rst_pulse", data_out, '0);
        acc(0, 0, 12'd5, 32'h0); step();
        check("post_rst_read", 256'(slice(0)), 256'h11);

        acc(2, 1, 12'd7, 32'hDEADBEEF); acc(5, 1, 12'd7, 32'h12345678); step();
        acc(2, 0, 12'd7, 32'h0); acc(5, 0, 12'd7, 32'h0); step();
        check("par_b2", 256'(slice(2)), 256'hDEADBEEF);
        check("par_b5", 256'(slice(5)), 256'h12345678);
        check("par_b0_hold", 256'(slice(0)), 256'h11);

        acc(3, 1, 12'd100, 32'h55); step();
        acc(3, 0, 12'd100, 32'h0); step();
        check("lat_b3", 256'(slice(3)), 256'h55);
        for (int k = 0; k < 5; k++) begin
            addr[3*12 +: 12] = 12'(k + 200);
            we[3] = 1'b1;
            data_in[3*32 +: 32] = 32'hBAD0 + k;
            step();
            check($sformatf("hold_b3_%0d", k), 256'(slice(3)), 256'h55);
        end
        acc(3, 0, 12'd200, 32'h0); step();
        check("we_no_en_b3", 256'(slice(3)) === 256'hBAD0 ? 256'h1 : 256'h0, 256'h0);

        acc(1, 1, 12'd9, 32'h01); step();
        we[1] = 1'b1; addr[12 +: 12] = 12'd9; data_in[32 +: 32] = 32'hFF; step();
        acc(1, 0, 12'd9, 32'h0); step();
        check("we_no_en_b1", 256'(slice(1)), 256'h01);

        acc(4, 1, 12'd0, 32'hA); step();
        acc(4, 1, 12'd0, 32'hB); step();
`ifdef MULTI_SRAM_WRITE_FIRST_EN
        check("rdw_b4", 256'(slice(4)), 256'hB);
`else
        check("rdw_b4", 256'(slice(4)), 256'hA);
`endif
        acc(4, 0, 12'd0, 32'h0); step();
        check("rdw_after_b4", 256'(slice(4)), 256'hB);

        acc(7, 1, 12'd0, 32'h1); step();
        acc(7, 1, 12'd4095, 32'h2); step();
        acc(7, 0, 12'd0, 32'h0); step();
        check("bnd_b7_lo", 256'(slice(7)), 256'h1);
        acc(7, 0, 12'd4095, 32'h0); step();
        check("bnd_b7_hi", 256'(slice(7)), 256'h2);
        check("bnd_b2_hold", 256'(slice(2)), 256'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multi_sram.md
Name: multi_sram

Overview:
- Bank of NUM_SRAMS independent single-port synchronous SRAMs behind flattened per-bank buses.
- Each bank has its own enable, write-enable, address and write data, and a registered read output.
- Sits directly below sram_controller, which arbitrates the GEMM, elementwise and AXI ports onto these per-bank lanes.
- All banks operate concurrently within the same cycle.

Parameters:
- NUM_SRAMS, 8: number of banks.
- MAX_ADDR_WIDTH, 12: address bits per bank; depth = 2**MAX_ADDR_WIDTH words.
- MAX_DATA_WIDTH, 32: stored word width per bank.
- SRAM_WIDTH_O, 32: read-data width per bank.

Ports:
- clk  in  1: sole clock; everything updates on its rising edge.
- rst  in  1: synchronous, active-high reset.
- en  in  NUM_SRAMS: bit i enables bank i for this cycle.
- we  in  NUM_SRAMS: bit i selects write for bank i; honoured only when en[i]=1.
- addr  in  NUM_SRAMS*MAX_ADDR_WIDTH: bank i address at [i*MAX_ADDR_WIDTH +: MAX_ADDR_WIDTH].
- data_in  in  NUM_SRAMS*MAX_DATA_WIDTH: bank i write data at [i*MAX_DATA_WIDTH +: MAX_DATA_WIDTH].
- data_out  out  NUM_SRAMS*SRAM_WIDTH_O: bank i registered read data at [i*SRAM_WIDTH_O +: SRAM_WIDTH_O]; signed.

Behaviour:
- Reset: while rst=1 at a rising edge, every data_out slice is set to 0.
  - Memory contents are not cleared.
  - All writes and reads are suppressed in that cycle.
- Banks are fully independent. Any combination of en/we bits may be active in one cycle, with no cross-bank interaction.
- Write: en[i]=1 and we[i]=1 at an edge stores data_in slice i into bank i at addr slice i.
- Read: en[i]=1 and we[i]=0 at an edge loads the word at addr slice i into data_out slice i.
  - Latency is 1 cycle: valid after the same edge that sampled the address.
- Write cycle output (en=1, we=1): data_out slice i is updated per the read-during-write rule (see Optional Feature).
- Hold: en[i]=0 keeps data_out slice i unchanged. we[i] is ignored when en[i]=0.
- Width rule:
  - If SRAM_WIDTH_O > MAX_DATA_WIDTH, the read word is sign-extended from its MSB.
  - If SRAM_WIDTH_O < MAX_DATA_WIDTH, the low SRAM_WIDTH_O bits are output.
  - If equal, the word passes unchanged.
- Address range: the full 0 to 2**MAX_ADDR_WIDTH-1 range is valid per bank, with no wrap or aliasing. All address values are legal.
- Uninitialised locations read as X in simulation; no read-back guarantee before the first write.
- Reset during traffic: the in-flight access is dropped. Previously written data stays intact and is readable after rst deasserts.
- No handshake and no stalls: every enabled access completes in one cycle.

Optional Feature:
- Macro: MULTI_SRAM_WRITE_FIRST_EN.
- Defined: on a write cycle, data_out slice i takes the newly written data_in value, width-adjusted per the width rule (write-first).
- Undefined (default): on a write cycle, data_out slice i takes the old contents of the addressed location (read-first).
- Either way, the stored word after the edge is data_in.

Decomposition:
- Shared package/header (existing params.vh set) holds NUM_SRAMS, MAX_ADDR_WIDTH, MAX_DATA_WIDTH and SRAM_WIDTH_O, so sram_controller and multi_sram agree.
- Sub-module sram_bank: one single-port synchronous RAM, depth 2**MAX_ADDR_WIDTH, with en, we, addr, din and a registered dout including the width rule.
  - multi_sram instantiates NUM_SRAMS of them via generate and only slices the flattened buses.

Test Plan:
- Reset: write 0x11 to bank 0 addr 5, then pulse rst one cycle → all data_out slices 0. Then read bank 0 addr 5 → 0x00000011 one cycle later.
- Parallel independence: same cycle, write bank 2 addr 7 = 0xDEADBEEF and bank 5 addr 7 = 0x12345678. Next cycle read both → respective values, with no crosstalk; other slices unchanged.
- Latency/hold: read bank 3 addr 100 (holding 0x55) with en high for one cycle only → 0x55 appears exactly one edge later and is held while en[3]=0 for 5 cycles.
- we without en: en[1]=0, we[1]=1, data 0xFF at addr 9 → subsequent read of addr 9 returns the prior value 0x01.
- Read-during-write at bank 4 addr 0 (old 0xA, new 0xB) → data_out slice 4 = 0xA without the macro, 0xB with MULTI_SRAM_WRITE_FIRST_EN. A following read returns 0xB.
- Boundary: write addr 0 = 0x1 and addr 4095 = 0x2 on bank 7 → reads return 0x1 and 0x2 respectively, with no aliasing.
